// File: rtl/pokey_serout_tx.sv
// pokey_serout_tx
//   POKEY serial output transmitter. The CPU writes a byte into a holding
//   register, and a shift register sends it as an async frame: a start bit,
//   then DATA_BITS data bits LSB first, then STOP_BITS stop bits. Each bit
//   lasts one timer borrow tick. All state updates on the falling clk edge
//   when enn=1.
//
//   Parameters:
//     DATA_BITS   data bits per frame (1..8)
//     STOP_BITS   stop bits per frame (1 or 2)
//
//   Ports:
//     clk        system clock (falling-edge active)
//     rst        asynchronous active-high reset
//     enn        clock enable
//     D          CPU data bus
//     WR         SEROUT write strobe; loads D into the holding register
//     bit_tick   timer borrow pulse; one bit period per tick
//     ndata_clr  clears the "output data needed" IRQ flag
//     sout       serial line, idles high
//     busy       shifter is inside a frame
//     ndata      latched "output data needed" IRQ flag
//     done       shifter idle and holding register empty
//
//   Optional build macro POKEY_SERBREAK_EN adds input force_break, which
//   holds sout low without disturbing frame timing.

module pokey_serout_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enn,
  input  logic [7:0] D,
  input  logic       WR,
  input  logic       bit_tick,
  input  logic       ndata_clr,
`ifdef POKEY_SERBREAK_EN
  input  logic       force_break,
`endif
  output logic       sout,
  output logic       busy,
  output logic       ndata,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       stopcnt_q, stopcnt_d;
  logic       sout_q, sout_d;
  logic       busy_q, busy_d;
  logic       ndata_q, ndata_d;
  logic       load;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    stopcnt_d   = stopcnt_q;
    sout_d      = sout_q;
    ndata_d     = ndata_q;
    load        = 1'b0;

    if (enn) begin
      if (ndata_clr) ndata_d = 1'b0;

      if (bit_tick) begin
        unique case (state_q)
          IDLE: begin
            if (hold_full_q) load = 1'b1;
          end
          START: begin
            state_d  = DATA;
            sout_d   = shift_q[0];
            bitcnt_d = '0;
          end
          DATA: begin
            if (bitcnt_q != LAST_BIT) begin
              sout_d   = shift_q[bitcnt_q + 3'd1];
              bitcnt_d = bitcnt_q + 3'd1;
            end else begin
              state_d   = STOP;
              sout_d    = 1'b1;
              stopcnt_d = 1'b0;
            end
          end
          STOP: begin
            if (stopcnt_q != LAST_STOP) begin
              stopcnt_d = stopcnt_q + 1'b1;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      // The transfer uses the old hold contents; a write on the same edge
      // lands afterwards and re-marks the holding register full. The load
      // also sets ndata after any clear, so set wins.
      if (load) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        ndata_d     = 1'b1;
        state_d     = START;
        sout_d      = 1'b0;
      end

      if (WR) begin
        hold_d      = D;
        hold_full_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      stopcnt_q   <= 1'b0;
      sout_q      <= 1'b1;
      busy_q      <= 1'b0;
      ndata_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      stopcnt_q   <= stopcnt_d;
      sout_q      <= sout_d;
      busy_q      <= busy_d;
      ndata_q     <= ndata_d;
    end
  end

`ifdef POKEY_SERBREAK_EN
  assign sout = sout_q & ~force_break;
`else
  assign sout = sout_q;
`endif
  assign busy  = busy_q;
  assign ndata = ndata_q;
  assign done  = (state_q == IDLE) && !hold_full_q;

endmodule

// File: tb/tb_pokey_serout_tx.sv
module tb_pokey_serout_tx;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic       enn = 1'b1;
  logic [7:0] d = 8'h00;
  logic       wr = 1'b0;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic       wr2 = 1'b0;
  logic       tick2 = 1'b0;
`ifdef POKEY_SERBREAK_EN
  logic       fb = 1'b0;
`endif
  logic       sout, busy, ndata, done;
  logic       sout2, busy2, ndata2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pokey_serout_tx dut (
    .clk(clk), .rst(rst), .enn(enn), .D(d), .WR(wr), .bit_tick(tick),
    .ndata_clr(clr),
`ifdef POKEY_SERBREAK_EN
    .force_break(fb),
`endif
    .sout(sout), .busy(busy), .ndata(ndata), .done(done)
  );

  pokey_serout_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enn(enn), .D(d), .WR(wr2), .bit_tick(tick2),
    .ndata_clr(clr),
`ifdef POKEY_SERBREAK_EN
    .force_break(1'b0),
`endif
    .sout(sout2), .busy(busy2), .ndata(ndata2), .done(done2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One falling edge with the given strobes, sampled 1 time unit later.
  task automatic cyc(input logic w, input logic [7:0] dv, input logic t,
                     input logic w2, input logic t2, input logic c);
    wr = w; d = dv; tick = t; wr2 = w2; tick2 = t2; clr = c;
    @(negedge clk);
    #1;
    wr = 1'b0; tick = 1'b0; wr2 = 1'b0; tick2 = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick16(input logic w, input logic [7:0] dv);
    idle(15);
    cyc(w, dv, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick4b();
    idle(3);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic data_chk(input logic [7:0] b, input string tag);
    for (int i = 0; i < 8; i++) begin
      tick16(1'b0, 8'h00);
      chk($sformatf("%s_bit%0d", tag, i), {7'b0, sout}, {7'b0, b[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    chk("rst_sout", {7'b0, sout}, 8'd1);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_ndata", {7'b0, ndata}, 8'd0);
    chk("rst_done", {7'b0, done}, 8'd1);
    rst = 1'b0;
    idle(2);

    // Single frame of A5
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_done_after_wr", {7'b0, done}, 8'd0);
    chk("a5_sout_after_wr", {7'b0, sout}, 8'd1);
    enn = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    enn = 1'b1;
    chk("enn0_tick_sout", {7'b0, sout}, 8'd1);
    chk("enn0_tick_busy", {7'b0, busy}, 8'd0);
    tick16(1'b0, 8'h00);
    chk("a5_start", {7'b0, sout}, 8'd0);
    chk("a5_ndata", {7'b0, ndata}, 8'd1);
    chk("a5_busy", {7'b0, busy}, 8'd1);
    data_chk(8'hA5, "a5");
    tick16(1'b0, 8'h00);
    chk("a5_stop", {7'b0, sout}, 8'd1);
    chk("a5_stop_busy", {7'b0, busy}, 8'd1);
    tick16(1'b0, 8'h00);
    chk("a5_end_done", {7'b0, done}, 8'd1);
    chk("a5_end_busy", {7'b0, busy}, 8'd0);
    chk("a5_end_sout", {7'b0, sout}, 8'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5_ndata_clr", {7'b0, ndata}, 8'd0);
    tick16(1'b0, 8'h00);
    chk("empty_tick_sout", {7'b0, sout}, 8'd1);
    chk("empty_tick_busy", {7'b0, busy}, 8'd0);

    // Back-to-back 00 then FF
    cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick16(1'b0, 8'h00);
    chk("b2b_start0", {7'b0, sout}, 8'd0);
    chk("b2b_ndata0", {7'b0, ndata}, 8'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_ndata_clr", {7'b0, ndata}, 8'd0);
    data_chk(8'h00, "b2b00");
    tick16(1'b0, 8'h00);
    chk("b2b_stop0", {7'b0, sout}, 8'd1);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick16(1'b0, 8'h00);
    chk("b2b_start1", {7'b0, sout}, 8'd0);
    chk("b2b_busy1", {7'b0, busy}, 8'd1);
    chk("b2b_ndata1", {7'b0, ndata}, 8'd1);
    data_chk(8'hFF, "b2bff");
    tick16(1'b0, 8'h00);
    chk("b2b_stop1", {7'b0, sout}, 8'd1);
    tick16(1'b0, 8'h00);
    chk("b2b_done", {7'b0, done}, 8'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Write on the transfer edge
    cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(15);
    cyc(1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("xfer_start", {7'b0, sout}, 8'd0);
    chk("xfer_done", {7'b0, done}, 8'd0);
    data_chk(8'h12, "xfer12");
    tick16(1'b0, 8'h00);
    chk("xfer_stop", {7'b0, sout}, 8'd1);
    tick16(1'b0, 8'h00);
    chk("xfer_start2", {7'b0, sout}, 8'd0);
    chk("xfer_busy2", {7'b0, busy}, 8'd1);
    data_chk(8'h34, "xfer34");
    tick16(1'b0, 8'h00);
    tick16(1'b0, 8'h00);
    chk("xfer_done2", {7'b0, done}, 8'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-DATA
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick16(1'b0, 8'h00);
    chk("mid_sout_before", {7'b0, sout}, 8'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_sout", {7'b0, sout}, 8'd1);
    chk("arst_busy", {7'b0, busy}, 8'd0);
    chk("arst_done", {7'b0, done}, 8'd1);
    chk("arst_ndata", {7'b0, ndata}, 8'd0);
    #1 rst = 1'b0;
    tick16(1'b0, 8'h00);
    chk("arst_tick_sout", {7'b0, sout}, 8'd1);
    chk("arst_tick_busy", {7'b0, busy}, 8'd0);

    // DATA_BITS=7, STOP_BITS=2 instance
    cyc(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tick4b();
    chk("p7_start", {7'b0, sout2}, 8'd0);
    for (int i = 0; i < 7; i++) begin
      tick4b();
      chk($sformatf("p7_bit%0d", i), {6'b0, busy2, sout2}, 8'd3);
    end
    tick4b();
    chk("p7_stop1", {6'b0, busy2, sout2}, 8'd3);
    tick4b();
    chk("p7_stop2", {6'b0, busy2, sout2}, 8'd3);
    tick4b();
    chk("p7_idle", {6'b0, busy2, done2}, 8'd1);
    chk("p7_ndata", {7'b0, ndata2}, 8'd1);

`ifdef POKEY_SERBREAK_EN
    // Forced break mid-frame, 0F = LSB first 1,1,1,1,0,0,0,0
    cyc(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    tick16(1'b0, 8'h00);
    chk("brk_start", {7'b0, sout}, 8'd0);
    tick16(1'b0, 8'h00);
    chk("brk_bit0", {7'b0, sout}, 8'd1);
    fb = 1'b1;
    #1;
    chk("brk_now", {7'b0, sout}, 8'd0);
    for (int i = 1; i < 4; i++) begin
      tick16(1'b0, 8'h00);
      chk($sformatf("brk_hold%0d", i), {7'b0, sout}, 8'd0);
    end
    fb = 1'b0;
    #1;
    chk("brk_release_bit3", {7'b0, sout}, 8'd1);
    for (int i = 4; i < 8; i++) begin
      tick16(1'b0, 8'h00);
      chk($sformatf("brk_bit%0d", i), {7'b0, sout}, 8'd0);
    end
    tick16(1'b0, 8'h00);
    chk("brk_stop", {7'b0, sout}, 8'd1);
    tick16(1'b0, 8'h00);
    chk("brk_done", {7'b0, done}, 8'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
